// File: rtl/imem_responder.sv
// imem_responder
// Word-organised on-chip SRAM that answers valid/ready bus requests after a
// fixed number of wait cycles. It supports byte-enabled writes, out-of-range
// error signalling and a full-word backdoor load port.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   mem_valid_i   - request present
//   mem_ready_o   - request completes this cycle (combinational)
//   mem_addr_i    - byte address, bits [1:0] ignored
//   mem_wdata_i   - write data
//   mem_we_i      - byte write enables, 0 = read
//   mem_rdata_o   - pre-write word contents on completion, else 0
//   mem_err_o     - address out of range, asserted with mem_ready_o
//   load_en_i     - backdoor full-word write strobe
//   load_addr_i   - backdoor byte address
//   load_data_i   - backdoor word
module imem_responder #(
    parameter int unsigned RISCV_ADDR_WIDTH = 32,
    parameter int unsigned RISCV_WORD_WIDTH = 32,
    parameter int unsigned DEPTH_WORDS      = 1024,
    parameter int unsigned LATENCY          = 2,
    parameter logic [RISCV_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_valid_i,
    output logic                        mem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] mem_wdata_i,
    input  logic [3:0]                  mem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] mem_rdata_o,
    output logic                        mem_err_o,
    input  logic                        load_en_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] load_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] load_data_i
);

    localparam int unsigned AW    = RISCV_ADDR_WIDTH;
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH_WORDS);
    localparam logic [3:0]    LAT_C   = 4'(LATENCY);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-3:0] held_addr_q;

    logic [RISCV_WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    // Address decode. The word offset is computed at full width so that a
    // huge offset cannot alias into range through truncation.
    logic [AW-1:0]    bus_woff, ld_woff;
    logic             bus_in, ld_in;
    logic [IDX_W-1:0] bus_idx, ld_idx;
    logic [AW-3:0]    bus_waddr;

    assign bus_woff  = (mem_addr_i - BASE_ADDR) >> 2;
    assign bus_in    = (mem_addr_i >= BASE_ADDR) && (bus_woff < DEPTH_A);
    assign bus_idx   = IDX_W'(bus_woff);
    assign ld_woff   = (load_addr_i - BASE_ADDR) >> 2;
    assign ld_in     = (load_addr_i >= BASE_ADDR) && (ld_woff < DEPTH_A);
    assign ld_idx    = IDX_W'(ld_woff);
    assign bus_waddr = mem_addr_i[AW-1:2];

    // Completion: immediate in IDLE when there are no wait cycles, otherwise
    // in WAIT once the same word address has been held for LATENCY cycles.
    logic complete;
    always_comb begin
        complete = 1'b0;
        if (!rst && mem_valid_i) begin
            if (state_q == IDLE)
                complete = (LATENCY == 0);
            else
                complete = (bus_waddr == held_addr_q) && (cnt_q == LAT_C);
        end
    end

    assign mem_ready_o = complete;
    assign mem_err_o   = complete && !bus_in;
    assign mem_rdata_o = (complete && bus_in) ? mem[bus_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            held_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_valid_i && LATENCY != 0) begin
                        held_addr_q <= bus_waddr;
                        cnt_q       <= 4'd1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_valid_i) begin
                        // Initiator withdrew: abandon without side effects.
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else if (bus_waddr != held_addr_q) begin
                        // New address counts as cycle 0 of a fresh request.
                        held_addr_q <= bus_waddr;
                        cnt_q       <= 4'd1;
                    end else if (cnt_q == LAT_C) begin
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage, not reset. The backdoor assignment comes last so that it
    // replaces the whole word when it collides with a bus write.
    always_ff @(posedge clk) begin
        if (complete && bus_in) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_i[b]) mem[bus_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
        end
        if (load_en_i && ld_in)
            mem[ld_idx] <= load_data_i;
    end

endmodule
